phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the width of the dwell counter and of each dwell register.
REQ-002 The block SHALL have parameter DWELL_RST, default 8'd4, meaning the reset value of all four dwell registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-004 The block SHALL have port state: input, 2 bits, the current state of the sequencing controller.
REQ-005 The block SHALL have port wr_en: input, 1 bit, dwell register write strobe.
REQ-006 The block SHALL have port wr_sel: input, 2 bits, index of the dwell register to write.
REQ-007 The block SHALL have port wr_data: input, CNT_W bits, the dwell value to write.
REQ-008 The block SHALL have port T: output, 1 bit, one-cycle timeout pulse to the controller.
REQ-009 The block SHALL have port cnt: output, CNT_W bits, the cycles spent in the current state.
REQ-010 The block SHALL have port fired: output, 1 bit, high once T has been issued for the current state visit.

Function
REQ-011 The block SHALL register state into state_q every cycle.
REQ-012 The block SHALL define "change" as state != state_q.
REQ-013 On a cycle with change, the block SHALL set cnt to 0, fired to 0 and T to 0.
REQ-014 Without change, the block SHALL increment cnt by 1 per cycle, saturating at all-ones, with no wrap-around.
REQ-015 Without change, when fired=0, dwell[state_q]!=0 and cnt==dwell[state_q]-1, the block SHALL set T to 1 and fired to 1 for the next cycle.
REQ-016 T SHALL be high for exactly one cycle per state visit.
REQ-017 T SHALL be low in every other cycle.
REQ-018 T SHALL rise dwell[state] cycles after the first clock edge at which the new state value is sampled.
REQ-019 A dwell value of 0 SHALL disable the timeout for that state: T is never asserted and fired stays 0.
REQ-020 Matching SHALL be by equality only: if the dwell register is rewritten to a value <= cnt mid-visit, T SHALL NOT fire during that visit.
REQ-021 When wr_en=1, the block SHALL load dwell[wr_sel] from wr_data at the clock edge.
REQ-022 A newly written dwell value SHALL be used for comparison from the following cycle.
REQ-023 A write and a state change in the same cycle SHALL both take effect; the change rule of REQ-013 has priority over the fire rule of REQ-015.
REQ-024 If state returns to its previous value within one cycle, the block SHALL treat it as a new visit (change seen -> restart).

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously set state_q=2'b00, cnt=0, T=0, fired=0 and all dwell registers to DWELL_RST.
REQ-026 Reset asserted mid-count SHALL abort any pending timeout.
REQ-027 After reset release, the first edge SHALL treat state as a change if state != 2'b00.
REQ-028 Reset deassertion SHALL take effect synchronously at the next clk rising edge.

Structure
REQ-029 State encodings (S_IDLE=2'b00, S_WAIT=2'b01, S_RUN=2'b10, S_DONE=2'b11) and the CNT_W default SHALL live in shared package phase_pkg, also used by the controller.
REQ-030 The four dwell registers and their write port SHALL be one sub-module, dwell_regfile, with an asynchronous read by index.
REQ-031 The counter, change detection and fire logic SHALL reside in phase_timer itself.

Verification
REQ-032 Scenario, basic timeout: after reset, hold state=2'b01 from the edge after reset release, with dwell[1]=4 -> T high exactly one cycle, 4 cycles after the first edge sampling 01; fired=1 afterwards; cnt saturates at 8'hFF.
REQ-033 Scenario, disabled dwell: write dwell[2]=0, then hold state=2'b10 for 300 cycles -> T never asserted, fired=0, cnt=8'hFF.
REQ-034 Scenario, late rewrite: with dwell[1]=10 and cnt=6, write dwell[1]=3 -> no T this visit; after leaving and re-entering 01, T fires 3 cycles after entry.
REQ-035 Scenario, mid-visit change: with dwell[1]=5, state 01 -> 10 at cnt=2 -> cnt=0, fired=0, T=0 at the next cycle, and the new dwell[2] governs.
REQ-036 Scenario, reset mid-count: assert rst_n=0 at cnt=3 -> T=0, cnt=0 immediately (asynchronous), dwell registers = 4.
REQ-037 Scenario, closed loop with controller: X=0, then T pulses -> controller cycles through 00, 01, 10, 11, 00, with 01 lasting dwell[1]+1 cycles.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared definitions for the phase sequencing controller and its timer.
// Holds the controller state encodings, the default counter width and a
// saturating-increment helper.
package phase_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // Controller state encodings
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
    return (v == '1) ? v : v + CNT_W_DEF'(1);
  endfunction

endpackage

// File: rtl/dwell_regfile.sv
// Four dwell registers with a single write port and an asynchronous read port.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (loads DWELL_RST)
//   i_wr_en     - write strobe
//   i_wr_sel    - register index to write
//   i_wr_data   - value to write
//   i_rd_sel    - register index to read
//   o_rd_data   - combinational read data
module dwell_regfile #(
  parameter int unsigned           CNT_W     = 8,
  parameter logic [CNT_W-1:0]      DWELL_RST = CNT_W'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [1:0]       i_wr_sel,
  input  logic [CNT_W-1:0] i_wr_data,
  input  logic [1:0]       i_rd_sel,
  output logic [CNT_W-1:0] o_rd_data
);

  logic [CNT_W-1:0] r_dwell [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_dwell[i] <= DWELL_RST;
      end
    end else if (i_wr_en) begin
      r_dwell[i_wr_sel] <= i_wr_data;
    end
  end

  assign o_rd_data = r_dwell[i_rd_sel];

endmodule

// File: rtl/phase_timer.sv
// Per-state dwell timer for the phase sequencing controller. Counts cycles
// spent in the current controller state and issues a single-cycle timeout
// pulse once the count reaches that state's programmed dwell.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   state      - current controller state
//   wr_en      - dwell register write strobe
//   wr_sel     - dwell register index to write
//   wr_data    - dwell value to write
//   T          - one-cycle timeout pulse
//   cnt        - cycles spent in the current state (saturating)
//   fired      - T already issued during this state visit
module phase_timer
  import phase_pkg::*;
#(
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DWELL_RST = CNT_W'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       state,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  output logic             T,
  output logic [CNT_W-1:0] cnt,
  output logic             fired
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       r_state_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_t;
  logic             r_fired;

  logic [CNT_W-1:0] w_dwell;
  logic             w_change;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_t_d;
  logic             w_fired_d;

  // Dwell is looked up for the registered state, i.e. the state being timed.
  dwell_regfile #(
    .CNT_W     (CNT_W),
    .DWELL_RST (DWELL_RST)
  ) u_dwell_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_sel  (wr_sel),
    .i_wr_data (wr_data),
    .i_rd_sel  (r_state_q),
    .o_rd_data (w_dwell)
  );

  assign w_change = (state != r_state_q);

  // Equality match only: a dwell rewritten below the current count never fires.
  assign w_hit = !r_fired && (w_dwell != '0) && (r_cnt == (w_dwell - ONE));

  always_comb begin
    w_cnt_d   = r_cnt;
    w_t_d     = 1'b0;
    w_fired_d = r_fired;
    if (w_change) begin
      w_cnt_d   = '0;
      w_fired_d = 1'b0;
    end else begin
      w_cnt_d = (r_cnt == '1) ? r_cnt : r_cnt + ONE;
      if (w_hit) begin
        w_t_d     = 1'b1;
        w_fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= S_IDLE;
      r_cnt     <= '0;
      r_t       <= 1'b0;
      r_fired   <= 1'b0;
    end else begin
      r_state_q <= state;
      r_cnt     <= w_cnt_d;
      r_t       <= w_t_d;
      r_fired   <= w_fired_d;
    end
  end

  assign T     = r_t;
  assign cnt   = r_cnt;
  assign fired = r_fired;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a cycle model predicts T/cnt/fired for
// every driven cycle, the prediction is queued and compared after the edge.
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       T;
  logic [7:0] cnt;
  logic       fired;

  phase_timer #(
    .CNT_W     (8),
    .DWELL_RST (8'd4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state   (state),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .T       (T),
    .cnt     (cnt),
    .fired   (fired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       t;
    logic       f;
    logic [7:0] c;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [1:0] m_sq;
  logic [7:0] m_cnt;
  logic       m_fired;
  logic [7:0] m_dwell [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_sq    = 2'b00;
    m_cnt   = 8'd0;
    m_fired = 1'b0;
    for (int i = 0; i < 4; i++) m_dwell[i] = 8'd4;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic [1:0] st, input logic we, input logic [1:0] sel,
                      input logic [7:0] d);
    exp_t e;
    state   = st;
    wr_en   = we;
    wr_sel  = sel;
    wr_data = d;
    if (st != m_sq) begin
      e = '{t: 1'b0, f: 1'b0, c: 8'd0};
    end else begin
      e.c = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      if (!m_fired && m_dwell[m_sq] != 8'd0 && m_cnt == m_dwell[m_sq] - 8'd1) begin
        e.t = 1'b1;
        e.f = 1'b1;
      end else begin
        e.t = 1'b0;
        e.f = m_fired;
      end
    end
    sb_q.push_back(e);
    if (we) m_dwell[sel] = d;
    m_sq    = st;
    m_cnt   = e.c;
    m_fired = e.f;
    @(posedge clk);
    #1;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("T", {31'd0, T}, {31'd0, e.t});
      check("cnt", {24'd0, cnt}, {24'd0, e.c});
      check("fired", {31'd0, fired}, {31'd0, e.f});
    end
  endtask

  // Hold one state for n cycles; report T pulse count and first pulse index.
  task automatic run(input logic [1:0] st, input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 0; i < n; i++) begin
      step(st, 1'b0, 2'b00, 8'd0);
      if (T) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  int         p;
  int         f;
  logic [1:0] ctrl;
  int         len;
  int         visits;
  logic [1:0] vis_st [5];
  int         vis_len [5];
  logic [1:0] exp_seq [5];

  initial begin
    rst_n   = 1'b0;
    state   = 2'b00;
    wr_en   = 1'b0;
    wr_sel  = 2'b00;
    wr_data = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_T", {31'd0, T}, 32'd0);
    check("rst_cnt", {24'd0, cnt}, 32'd0);
    check("rst_fired", {31'd0, fired}, 32'd0);
    rst_n = 1'b1;

    // Basic timeout with reset dwell of 4
    run(2'b01, 300, p, f);
    check("s1_first", f, 4);
    check("s1_pulses", p, 1);
    check("s1_cnt_sat", {24'd0, cnt}, 32'hFF);
    check("s1_fired", {31'd0, fired}, 32'd1);

    // Disabled dwell
    step(2'b01, 1'b1, 2'd2, 8'd0);
    run(2'b10, 300, p, f);
    check("s2_pulses", p, 0);
    check("s2_fired", {31'd0, fired}, 32'd0);
    check("s2_cnt_sat", {24'd0, cnt}, 32'hFF);

    // Late rewrite below current count
    step(2'b10, 1'b1, 2'd1, 8'd10);
    run(2'b01, 7, p, f);
    check("s3_cnt6", {24'd0, cnt}, 32'd6);
    step(2'b01, 1'b1, 2'd1, 8'd3);
    run(2'b01, 30, p, f);
    check("s3_no_fire", p, 0);
    run(2'b10, 2, p, f);
    run(2'b01, 10, p, f);
    check("s3_reentry_first", f, 3);

    // Mid-visit change
    step(2'b00, 1'b1, 2'd1, 8'd5);
    step(2'b00, 1'b1, 2'd2, 8'd2);
    run(2'b01, 3, p, f);
    check("s4_cnt2", {24'd0, cnt}, 32'd2);
    run(2'b10, 11, p, f);
    check("s4_new_dwell_first", f, 2);
    check("s4_pulses", p, 1);

    // Reset mid-count aborts pending timeout
    step(2'b00, 1'b0, 2'd0, 8'd0);
    run(2'b01, 4, p, f);
    check("s5_cnt3", {24'd0, cnt}, 32'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("s5_async_T", {31'd0, T}, 32'd0);
    check("s5_async_cnt", {24'd0, cnt}, 32'd0);
    check("s5_async_fired", {31'd0, fired}, 32'd0);
    #2 rst_n = 1'b1;
    run(2'b01, 10, p, f);
    check("s5_dwell_rst_first", f, 4);

    // Closed loop with a controller that advances on T
    step(2'b01, 1'b1, 2'd1, 8'd5);
    step(2'b01, 1'b1, 2'd2, 8'd2);
    exp_seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    ctrl   = 2'b00;
    len    = 0;
    visits = 0;
    for (int i = 0; i < 200 && visits < 5; i++) begin
      step(ctrl, 1'b0, 2'd0, 8'd0);
      len++;
      if (T) begin
        vis_st[visits]  = ctrl;
        vis_len[visits] = len;
        visits++;
        ctrl = ctrl + 2'b01;
        len  = 0;
      end
    end
    check("s6_visits", visits, 5);
    for (int i = 0; i < visits; i++) check("s6_seq", {30'd0, vis_st[i]}, {30'd0, exp_seq[i]});
    if (visits > 1) check("s6_wait_len", vis_len[1], 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
